// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: accept, one-cycle access,
// registered response. Misaligned or illegal accesses are rejected without touching memory.
module dmem_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  lsHB0,
  input  logic [1:0]  lsHB1,
  input  logic        lU0,
  input  logic        lU1,
  input  logic [10:0] addr0,
  input  logic [10:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_lsHB,
  output logic        mem_lU,
  output logic [10:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

  state_t      r_state, w_state_next;
  logic        w_gnt0, w_gnt1, w_accept;
  logic        r_ptr;
  logic        r_owner, r_we, r_lu, r_illegal;
  logic [1:0]  r_hb;
  logic [10:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rvalid0, r_rvalid1, r_err0, r_err1;
  logic [31:0] r_rdata0, r_rdata1;
  logic        w_sel_we, w_sel_lu;
  logic [1:0]  w_sel_hb;
  logic [10:0] w_sel_addr;
  logic [31:0] w_sel_wdata, w_resp_data;

  function automatic logic f_illegal(input logic [1:0] hb, input logic [1:0] a);
    return (hb == 2'b11) || ((hb == 2'b00) && (a != 2'b00)) || ((hb == 2'b10) && a[0]);
  endfunction

  // Arbitration and next state; grants are suppressed while reset is asserted.
  always_comb begin
    w_state_next = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    if (!rst && ((r_state == StIdle) || (r_state == StResp))) begin
      if (req0 && req1) begin
        if ((FIXED_PRIO != 0) || !r_ptr) w_gnt0 = 1'b1;
        else                             w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
    w_accept = w_gnt0 | w_gnt1;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = StAccess;
      StAccess: w_state_next = StResp;
      StResp:   w_state_next = w_accept ? StAccess : StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_sel_we    = w_gnt1 ? we1    : we0;
    w_sel_hb    = w_gnt1 ? lsHB1  : lsHB0;
    w_sel_lu    = w_gnt1 ? lU1    : lU0;
    w_sel_addr  = w_gnt1 ? addr1  : addr0;
    w_sel_wdata = w_gnt1 ? wdata1 : wdata0;
    w_resp_data = (r_illegal || r_we) ? 32'h0 : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_lu      <= 1'b0;
      r_illegal <= 1'b0;
      r_hb      <= 2'b00;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_owner   <= w_gnt1;
        r_ptr     <= w_gnt0;
        r_we      <= w_sel_we;
        r_hb      <= w_sel_hb;
        r_lu      <= w_sel_lu;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_illegal <= f_illegal(w_sel_hb, w_sel_addr[1:0]);
      end
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      // The rising edge that ends ACCESS captures the memory read into the response.
      if (r_state == StAccess) begin
        if (r_owner) begin
          r_rvalid1 <= 1'b1;
          r_err1    <= r_illegal;
          r_rdata1  <= w_resp_data;
        end else begin
          r_rvalid0 <= 1'b1;
          r_err0    <= r_illegal;
          r_rdata0  <= w_resp_data;
        end
      end
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign mem_read  = (r_state == StAccess) && !r_illegal && !r_we;
  assign mem_write = (r_state == StAccess) && !r_illegal && r_we;
  assign mem_lsHB  = r_hb;
  assign mem_lU    = r_lu;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
